// File: rtl/seq_hit_window_counter.sv
// Hit counter over a window of WIN_LEN qualified bit periods. At the end of each
// window it reports the hit count and a threshold alarm. Optional macro: SEQ_HIT_AUTO_RESTART_EN.
module seq_hit_window_counter #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hit,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] win_count,
  output logic             count_valid,
  output logic             alarm
);

  localparam int BIT_W = $clog2(WIN_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] SAT_VAL  = '1;
  // A threshold above the saturation value clamps to 2^CNT_W, which the accumulator can never reach.
  localparam logic [CNT_W:0]   THRESH_C = (THRESH > (2 ** CNT_W) - 1) ?
                                          {1'b1, {CNT_W{1'b0}}} : (CNT_W + 1)'(THRESH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_REPORT
  } state_t;

  state_t             state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   hit_acc_q, hit_acc_d;
  logic [CNT_W-1:0]   win_count_q, win_count_d;
  logic               alarm_q, alarm_d;
  logic               count_valid_q, count_valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   hit_acc_inc;

  always_comb begin
    hit_acc_inc = (hit && (hit_acc_q != SAT_VAL)) ? hit_acc_q + CNT_W'(1) : hit_acc_q;
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    hit_acc_d     = hit_acc_q;
    win_count_d   = win_count_q;
    alarm_d       = alarm_q;
    count_valid_d = 1'b0;
    busy_d        = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_COUNT;
          bit_cnt_d = '0;
          hit_acc_d = '0;
          busy_d    = 1'b1;
        end
      end

      S_COUNT: begin
        if (en) begin
          if (bit_cnt_q == LAST_BIT) begin
            // The final bit is folded in here so the report carries all WIN_LEN bits.
            win_count_d   = hit_acc_inc;
            alarm_d       = ({1'b0, hit_acc_inc} >= THRESH_C);
            count_valid_d = 1'b1;
            busy_d        = 1'b0;
            state_d       = S_REPORT;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            hit_acc_d = hit_acc_inc;
          end
        end
      end

      S_REPORT: begin
`ifdef SEQ_HIT_AUTO_RESTART_EN
        state_d   = S_COUNT;
        bit_cnt_d = '0;
        hit_acc_d = '0;
        busy_d    = 1'b1;
`else
        if (start) begin
          state_d   = S_COUNT;
          bit_cnt_d = '0;
          hit_acc_d = '0;
          busy_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      hit_acc_q     <= '0;
      win_count_q   <= '0;
      alarm_q       <= 1'b0;
      count_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      hit_acc_q     <= hit_acc_d;
      win_count_q   <= win_count_d;
      alarm_q       <= alarm_d;
      count_valid_q <= count_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign win_count   = win_count_q;
  assign count_valid = count_valid_q;
  assign alarm       = alarm_q;

endmodule

// File: tb/tb_seq_hit_window_counter.sv
// Scoreboard bench for seq_hit_window_counter: drivers push expected reports,
// per-instance monitors pop and compare on every count_valid strobe.
module tb_seq_hit_window_counter;

  typedef struct {
    int cnt;
    int alm;
    int cyc;
  } exp_t;

  logic clk;
  logic rst, start, en, hit;
  logic rst2, start2, en2, hit2;
  logic       busy1, cv1, alm1;
  logic [7:0] wc1;
  logic       busy2, cv2, alm2;
  logic [3:0] wc2;
  logic       busy3, cv3, alm3;
  logic [1:0] wc3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];
  exp_t e1, e2, e3;

  seq_hit_window_counter dut1 (
    .clk(clk), .rst(rst), .en(en), .hit(hit), .start(start),
    .busy(busy1), .win_count(wc1), .count_valid(cv1), .alarm(alm1)
  );

  seq_hit_window_counter #(.CNT_W(4), .WIN_LEN(32), .THRESH(3)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .hit(hit2), .start(start2),
    .busy(busy2), .win_count(wc2), .count_valid(cv2), .alarm(alm2)
  );

  // Threshold above the 2-bit saturation value: must never alarm.
  seq_hit_window_counter #(.CNT_W(2), .WIN_LEN(32), .THRESH(5)) dut3 (
    .clk(clk), .rst(rst2), .en(en2), .hit(hit2), .start(start2),
    .busy(busy3), .win_count(wc3), .count_valid(cv3), .alarm(alm3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", nm, act, req, cyc);
    end else begin
      $display("check %s value=%0d ok (cyc=%0d)", nm, act, cyc);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic e, input logic h);
    rst = r; start = s; en = e; hit = h;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic r, input logic s, input logic e, input logic h);
    rst2 = r; start2 = s; en2 = e; hit2 = h;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int c, input int a);
    q1.push_back('{cnt: c, alm: a, cyc: cyc});
  endtask

  always @(negedge clk) begin
    if (cv1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_strobe actual=strobe win_count=%0d required=no strobe (cyc=%0d)", wc1, cyc);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_win_count", int'(wc1), e1.cnt);
        chk("dut1_alarm", int'(alm1), e1.alm);
        chk("dut1_strobe_cycle", cyc, e1.cyc);
        chk("dut1_busy_in_report", int'(busy1), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (cv2 === 1'b1) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut2_unexpected_strobe actual=strobe required=no strobe (cyc=%0d)", cyc);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_win_count", int'(wc2), e2.cnt);
        chk("dut2_alarm", int'(alm2), e2.alm);
        chk("dut2_strobe_cycle", cyc, e2.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (cv3 === 1'b1) begin
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut3_unexpected_strobe actual=strobe required=no strobe (cyc=%0d)", cyc);
      end else begin
        e3 = q3.pop_front();
        chk("dut3_win_count", int'(wc3), e3.cnt);
        chk("dut3_alarm", int'(alm3), e3.alm);
        chk("dut3_strobe_cycle", cyc, e3.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish (cyc=%0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; start = 1'b0; en = 1'b0; hit = 1'b0;
    rst2 = 1'b1; start2 = 1'b0; en2 = 1'b0; hit2 = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: reset dominates start/en/hit.
    drive(1, 1, 1, 1);
    drive(1, 1, 1, 1);
    chk("reset_win_count", int'(wc1), 0);
    chk("reset_count_valid", int'(cv1), 0);
    chk("reset_alarm", int'(alm1), 0);
    chk("reset_busy", int'(busy1), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1);
      chk("idle_busy", int'(busy1), 0);
    end

    // Test 2: hits on qualified bits 3, 6, 9; start-cycle hit not counted.
    drive(0, 1, 1, 1);
    chk("busy_after_start", int'(busy1), 1);
    for (int b = 1; b <= 16; b++) begin
      drive(0, 0, 1, (b == 3 || b == 6 || b == 9));
      if (b == 8) chk("held_win_count_w1", int'(wc1), 0);
    end
    push1(3, 1);

    // Test 3: start in the REPORT cycle; hits on bits 1 and 16; start ignored mid-window.
    drive(0, 1, 1, 1);
    chk("busy_restart_w2", int'(busy1), 1);
    for (int b = 1; b <= 16; b++) begin
      drive(0, (b == 5), 1, (b == 1 || b == 16));
      if (b == 8) begin
        chk("held_win_count_w2", int'(wc1), 3);
        chk("held_alarm_w2", int'(alm1), 1);
      end
    end
    push1(2, 0);

    // Test 4: 4-cycle en=0 gap with hit=1 mid-window; hits on qualified bits 2, 5, 12.
    drive(0, 1, 1, 1);
    for (int b = 1; b <= 16; b++) begin
      drive(0, 0, 1, (b == 2 || b == 5 || b == 12));
      if (b == 8) begin
        for (int g = 0; g < 4; g++) drive(0, 0, 0, 1);
        chk("busy_in_gap", int'(busy1), 1);
        chk("held_win_count_gap", int'(wc1), 2);
      end
    end
    push1(3, 1);

    // Test 5: reset at the 8th qualified bit, then a fresh window.
    drive(0, 1, 1, 1);
    for (int b = 1; b <= 7; b++) drive(0, 0, 1, 1);
    drive(1, 0, 1, 1);
    chk("midrst_win_count", int'(wc1), 0);
    chk("midrst_alarm", int'(alm1), 0);
    chk("midrst_busy", int'(busy1), 0);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);
    chk("post_rst_idle_busy", int'(busy1), 0);
    drive(0, 1, 0, 0);
    for (int b = 1; b <= 16; b++) drive(0, 0, 1, (b == 16));
    push1(1, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 1);
`ifdef SEQ_HIT_AUTO_RESTART_EN
    chk("auto_restart_busy", int'(busy1), 1);
`else
    chk("report_to_idle_busy", int'(busy1), 0);
`endif
    chk("held_win_count_final", int'(wc1), 1);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Test 6: saturation with hit on every bit (CNT_W=4 and CNT_W=2 instances).
    drive2(1, 0, 0, 0);
    drive2(0, 1, 1, 1);
    for (int b = 1; b <= 32; b++) drive2(0, 0, 1, 1);
    q2.push_back('{cnt: 15, alm: 1, cyc: cyc});
    q3.push_back('{cnt: 3, alm: 0, cyc: cyc});
`ifdef SEQ_HIT_AUTO_RESTART_EN
    for (int b = 1; b <= 33; b++) drive2(0, 0, 1, 1);
    q2.push_back('{cnt: 15, alm: 1, cyc: cyc});
    q3.push_back('{cnt: 3, alm: 0, cyc: cyc});
`endif
    for (int i = 0; i < 4; i++) drive2(0, 0, 0, 0);
    drive2(1, 0, 0, 0);
    drive2(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    chk("pending_dut1", q1.size(), 0);
    chk("pending_dut2", q2.size(), 0);
    chk("pending_dut3", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
